// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache; one aligned 32-bit word per line.
// Define CACHE_STATS_EN to build saturating load hit/miss counters (tied to zero otherwise).
module data_cache #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SETS       = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  WE,
  input  logic                  StSrcM,
  input  logic                  LdSrcM,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_st,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned TAG = ADDR_WIDTH - 2 - IDX;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StStore,
    StBypass,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]       valid_q, valid_d;
  logic [TAG-1:0]        tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];
  logic [DATA_WIDTH-1:0] done_q, done_d;

  logic [1:0]            off;
  logic [IDX-1:0]        idx;
  logic [IDX-1:0]        idx_next;
  logic [TAG-1:0]        tag;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [7:0]            cur_byte;
  logic [DATA_WIDTH-1:0] merged_data;
  logic                  hit;
  logic                  misaligned;
  logic                  load_hit;

  logic                  line_we;
  logic [DATA_WIDTH-1:0] line_wdata;

  assign off      = A[1:0];
  assign idx      = A[IDX+1:2];
  assign idx_next = idx + 1'b1;
  assign tag      = A[ADDR_WIDTH-1:IDX+2];

  assign cur_data = data_q[idx];
  assign cur_byte = cur_data[{off, 3'b000} +: 8];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);

  // Byte accesses never straddle a word, so only LW/SW can be misaligned.
  assign misaligned = (off != 2'b00) && (WE ? !StSrcM : !LdSrcM);
  assign load_hit   = req_valid && !WE && !misaligned && hit;

  always_comb begin
    merged_data = cur_data;
    merged_data[{off, 3'b000} +: 8] = WD[7:0];
  end

  assign mem_st    = StSrcM;
  assign mem_wdata = WD;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    done_d     = done_q;
    line_we    = 1'b0;
    line_wdata = cur_data;
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = A;
    RD         = '0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WE) begin
            stall   = 1'b1;
            state_d = StStore;
          end else if (misaligned) begin
            stall   = 1'b1;
            state_d = StBypass;
          end else if (hit) begin
            RD = LdSrcM ? {{(DATA_WIDTH-8){1'b0}}, cur_byte} : cur_data;
          end else begin
            stall   = 1'b1;
            state_d = StFill;
          end
        end
      end
      StFill: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {A[ADDR_WIDTH-1:2], 2'b00};
        if (mem_ready) begin
          line_we      = 1'b1;
          line_wdata   = mem_rdata;
          valid_d[idx] = 1'b1;
          state_d      = StIdle;
        end
      end
      StStore: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          state_d = StDone;
          if (misaligned) begin
            // A misaligned word store touches this line and the following one.
            valid_d[idx]      = 1'b0;
            valid_d[idx_next] = 1'b0;
          end else if (hit) begin
            line_we    = 1'b1;
            line_wdata = StSrcM ? merged_data : WD;
          end
        end
      end
      StBypass: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          done_d  = mem_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        RD      = done_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (!rst_n) begin
      stall   = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      RD      = '0;
      line_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Tag and data arrays need no reset; valid_q qualifies them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= line_wdata;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        hit_inc;
  logic        miss_inc;

  assign hit_inc  = rst_n && (state_q == StIdle) && load_hit;
  assign miss_inc = rst_n && (state_q == StIdle) && req_valid && !WE && !misaligned && !hit;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit_inc && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (miss_inc && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_load_hit;
  assign unused_load_hit = load_hit;
  assign hit_count       = '0;
  assign miss_count      = '0;
`endif

endmodule
